// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage between fetch and
// decode/execute. Decodes and sign-extends the RV I/S/B/U/J immediates to
// XLEN bits. The instruction travels with its immediate through a valid/ready
// stage that has a 2-entry skid buffer (output register + skid register).
// Optional feature: define IMM_GEN_ZIMM_EN to make ImmSel 3'b101 the CSR zimm
// format (zero-extended Instr[19:15]); without it 3'b101 is flagged illegal.
module imm_gen_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_IMM = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSel,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [31:0]     OutInstr,
    output logic [XLEN-1:0] ExtImm,
    output logic            ImmErr
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic            out_err_q, out_err_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_err_q, skid_err_d;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_new;
    logic            imm_err_new;
    logic            in_fire;
    logic            out_fire;

    // Handshake decode; InReady comes straight from the state register so
    // there is no combinational path from OutReady to InReady.
    assign InReady  = (state_q != FULL);
    assign OutValid = (state_q != EMPTY);
    assign in_fire  = InValid & InReady;
    assign out_fire = OutValid & OutReady;

    // While empty the outputs show their idle values rather than stale data.
    assign OutInstr = OutValid ? out_instr_q : 32'h0;
    assign ExtImm   = OutValid ? out_imm_q : RESET_IMM;
    assign ImmErr   = OutValid & out_err_q;

    // Immediate decode of the incoming instruction. Every format places the
    // instruction sign bit at bit 31, so widening to XLEN just replicates it;
    // illegal selects and zimm leave bit 31 clear and thus extend with zeros.
    always_comb begin
        imm32       = 32'h0;
        imm_err_new = 1'b0;
        case (ImmSel)
            3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
            3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            3'b010: imm32 = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            3'b011: imm32 = {Instr[31:12], 12'h000};
            3'b100: imm32 = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            3'b101: imm32 = {27'h0, Instr[19:15]};
`else
            3'b101: imm_err_new = 1'b1;
`endif
            default: imm_err_new = 1'b1;
        endcase
        imm_new       = {XLEN{imm32[31]}};
        imm_new[31:0] = imm32;
    end

    // Next-state and datapath load control for the output/skid registers.
    always_comb begin
        state_d      = state_q;
        out_instr_d  = out_instr_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_instr_d = skid_instr_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (Flush) begin
            // Drop everything held and any input offered this cycle.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        out_instr_d = Instr;
                        out_imm_d   = imm_new;
                        out_err_d   = imm_err_new;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_instr_d = Instr;
                        out_imm_d   = imm_new;
                        out_err_d   = imm_err_new;
                    end else if (in_fire) begin
                        state_d      = FULL;
                        skid_instr_d = Instr;
                        skid_imm_d   = imm_new;
                        skid_err_d   = imm_err_new;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        out_instr_d = skid_instr_q;
                        out_imm_d   = skid_imm_q;
                        out_err_d   = skid_err_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers; reset empties both slots at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            out_instr_q  <= 32'h0;
            out_imm_q    <= RESET_IMM;
            out_err_q    <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_imm_q   <= RESET_IMM;
            skid_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_instr_q  <= out_instr_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_instr_q <= skid_instr_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: a 32-bit and a 64-bit instance share
// the same stimulus; expected entries are queued on acceptance and a monitor
// pops and compares whenever an output fires.
module tb_imm_gen_stage;

    localparam logic [31:0] R32 = 32'hDEADBEEF;
    localparam logic [63:0] R64 = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_sel;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] out_instr32, ext32;
    logic        in_ready64, out_valid64, err64;
    logic [31:0] out_instr64;
    logic [63:0] ext64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .RESET_IMM(R32)) u32 (
        .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid),
        .InReady(in_ready32), .Instr(instr), .ImmSel(imm_sel),
        .OutValid(out_valid32), .OutReady(out_ready), .OutInstr(out_instr32),
        .ExtImm(ext32), .ImmErr(err32)
    );

    imm_gen_stage #(.XLEN(64), .RESET_IMM(R64)) u64 (
        .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid),
        .InReady(in_ready64), .Instr(instr), .ImmSel(imm_sel),
        .OutValid(out_valid64), .OutReady(out_ready), .OutInstr(out_instr64),
        .ExtImm(ext64), .ImmErr(err64)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   out_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output fire must match the oldest accepted entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid32 && out_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got instr %h expected no output", out_instr32);
            end else begin
                e = sb.pop_front();
                $display("[TB] out instr=%h imm32=%h imm64=%h err=%b", out_instr32, ext32, ext64, err32);
                check("out_instr32", {32'h0, out_instr32}, {32'h0, e.instr});
                check("ext_imm32", {32'h0, ext32}, {32'h0, e.imm});
                check("imm_err32", {63'h0, err32}, {63'h0, e.err});
                check("out_valid64", {63'h0, out_valid64}, 64'h1);
                check("out_instr64", {32'h0, out_instr64}, {32'h0, e.instr});
                check("ext_imm64", ext64, {{32{e.imm[31]}}, e.imm});
                check("imm_err64", {63'h0, err64}, {63'h0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted (bounded).
    task automatic send(input logic [31:0] i, input logic [2:0] s,
                        input logic [31:0] imm, input logic e);
        exp_t x;
        int   n;
        n        = 0;
        in_valid = 1'b1;
        instr    = i;
        imm_sel  = s;
        while (!in_ready32 && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready32) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else begin
            x.instr = i;
            x.imm   = imm;
            x.err   = e;
            sb.push_back(x);
            $display("[TB] in  instr=%h sel=%b expect imm=%h err=%b", i, s, imm, e);
            tick();
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; imm_sel = 3'b000;
        tick(); tick();
        check("rst_out_valid", {63'h0, out_valid32}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready32}, 64'h1);
        check("rst_imm_err", {63'h0, err32}, 64'h0);
        check("rst_ext_imm32", {32'h0, ext32}, {32'h0, R32});
        check("rst_ext_imm64", ext64, R64);
        check("rst_out_instr", {32'h0, out_instr32}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Back-to-back formats with OutReady held high.
        out_ready = 1'b1;
        c0 = out_cnt;
        send(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
        send(32'h00002423, 3'b001, 32'h00000008, 1'b0);
        send(32'hFE000E63, 3'b010, 32'hFFFFF7FC, 1'b0);
        send(32'h0010006F, 3'b100, 32'h00000800, 1'b0);
        send(32'h123450B7, 3'b011, 32'h12345000, 1'b0);
        in_valid = 1'b0;
        check("stream_throughput", out_cnt - c0, 64'd4);
        idle(3);
        check("stream_count", out_cnt - c0, 64'd5);

        // 64-bit sign extension, illegal selects, zimm.
        send(32'h800000B7, 3'b011, 32'h80000000, 1'b0);
        send(32'h7FF00093, 3'b000, 32'h000007FF, 1'b0);
        send(32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
        send(32'h80012345, 3'b110, 32'h00000000, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
        send(32'h800A8073, 3'b101, 32'h00000015, 1'b0);
`else
        send(32'h800A8073, 3'b101, 32'h00000000, 1'b1);
`endif
        idle(3);

        // Backpressure: two accepted, then stall, then drain.
        out_ready = 1'b0;
        send(32'h00100093, 3'b000, 32'h00000001, 1'b0);
        send(32'h00200113, 3'b000, 32'h00000002, 1'b0);
        in_valid = 1'b1; instr = 32'h00300193; imm_sel = 3'b000;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", {63'h0, in_ready32}, 64'h0);
            check("bp_in_ready64_low", {63'h0, in_ready64}, 64'h0);
            check("bp_hold_instr", {32'h0, out_instr32}, 64'h00100093);
            check("bp_hold_imm", {32'h0, ext32}, 64'h1);
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        c0 = out_cnt;
        send(32'h00300193, 3'b000, 32'h00000003, 1'b0);
        send(32'h00400213, 3'b000, 32'h00000004, 1'b0);
        idle(1);
        check("bp_no_gaps", out_cnt - c0, 64'd4);
        check("bp_drained", {63'h0, out_valid32}, 64'h0);

        // Flush while FULL with an input offered in the flush cycle.
        out_ready = 1'b0;
        send(32'h00500293, 3'b000, 32'h00000005, 1'b0);
        send(32'h00600313, 3'b000, 32'h00000006, 1'b0);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00700393; imm_sel = 3'b000;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", {63'h0, out_valid32}, 64'h0);
        check("flush_in_ready", {63'h0, in_ready32}, 64'h1);
        check("flush_ext_imm32", {32'h0, ext32}, {32'h0, R32});
        check("flush_ext_imm64", ext64, R64);
        check("flush_imm_err", {63'h0, err32}, 64'h0);
        out_ready = 1'b1;
        c0 = out_cnt;
        idle(5);
        check("flush_no_emit", out_cnt - c0, 64'd0);

        // Asynchronous reset mid-cycle while FULL with an erroneous entry.
        out_ready = 1'b0;
        send(32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
        send(32'h00800413, 3'b000, 32'h00000008, 1'b0);
        in_valid = 1'b0;
        check("pre_reset_err", {63'h0, err32}, 64'h1);
        check("pre_reset_full", {63'h0, in_ready32}, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'h0, out_valid32}, 64'h0);
        check("async_rst_err", {63'h0, err32}, 64'h0);
        sb.delete();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        c0 = out_cnt;
        idle(5);
        check("rst_no_stale", out_cnt - c0, 64'd0);
        check("rst_idle_valid", {63'h0, out_valid32}, 64'h0);

        check("scoreboard_empty", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
